command_credit_arbiter: RTL and testbench

Sits between the read/write command buffers and the PSL command port in AFU-Control. Each cycle it picks at most one pending command, read or write, that has a free credit, and forwards it to the command output register. It keeps separate read and write credit pools, fills each pool back from response completions, and flags any credit return that would overflow a pool.

---
 rtl/command_credit_arbiter_pkg.sv | 6 +
 rtl/command_credit_arbiter_if.sv | 39 +++
 rtl/command_credit_arbiter_credit_counter.sv | 37 +++
 rtl/command_credit_arbiter.sv | 60 ++++++
 tb/tb_command_credit_arbiter.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/command_credit_arbiter_pkg.sv
// GLOBALS_AFU_PKG: shared AFU constants and the command direction type.
package GLOBALS_AFU_PKG;
  localparam int CREDITS_READ = 32;
  localparam int CREDITS_WRITE = 32;
  typedef enum logic {CMD_READ, CMD_WRITE} cmd_dir_t;
endpackage

// File: rtl/command_credit_arbiter_if.sv
// command_credit_arbiter_if: command buffer, PSL command and credit status bundle.
// slave: arbiter side (receives buffer heads and credit returns, drives grants,
//   the command output register, pool counts and sticky overflow flags).
// master: environment side, directions mirrored.
interface command_credit_arbiter_if import GLOBALS_AFU_PKG::*; #(
  parameter int CMD_WIDTH = 128,
  parameter int READ_CREDITS = CREDITS_READ,
  parameter int WRITE_CREDITS = CREDITS_WRITE
);
  localparam int RW = $clog2(READ_CREDITS + 1);
  localparam int WW = $clog2(WRITE_CREDITS + 1);
  logic enabled_in;
  logic read_cmd_valid;
  logic [CMD_WIDTH-1:0] read_cmd_in;
  logic read_cmd_grant;
  logic write_cmd_valid;
  logic [CMD_WIDTH-1:0] write_cmd_in;
  logic write_cmd_grant;
  logic read_rsp_done;
  logic write_rsp_done;
  logic cmd_out_valid;
  logic [CMD_WIDTH-1:0] cmd_out;
  logic cmd_out_is_write;
  logic [RW-1:0] read_credits_avail;
  logic [WW-1:0] write_credits_avail;
  logic [1:0] credit_overflow_error;
  modport slave (
    input enabled_in, read_cmd_valid, read_cmd_in, write_cmd_valid, write_cmd_in,
      read_rsp_done, write_rsp_done,
    output read_cmd_grant, write_cmd_grant, cmd_out_valid, cmd_out, cmd_out_is_write,
      read_credits_avail, write_credits_avail, credit_overflow_error
  );
  modport master (
    output enabled_in, read_cmd_valid, read_cmd_in, write_cmd_valid, write_cmd_in,
      read_rsp_done, write_rsp_done,
    input read_cmd_grant, write_cmd_grant, cmd_out_valid, cmd_out, cmd_out_is_write,
      read_credits_avail, write_credits_avail, credit_overflow_error
  );
endinterface

// File: rtl/command_credit_arbiter_credit_counter.sv
// credit_counter: one credit pool, reset full, with sticky overflow flag.
// Ports: clock, rstn (async active-low), take (grant), give (return),
//   count, nonzero, overflow (set by a return into a full pool without a take).
module credit_counter #(
  parameter int MAX = 32,
  parameter int W = $clog2(MAX + 1)
) (
  input  logic clock,
  input  logic rstn,
  input  logic take,
  input  logic give,
  output logic [W-1:0] count,
  output logic nonzero,
  output logic overflow
);
  logic [W-1:0] count_q, count_d;
  logic err_q, err_d;
  logic full;
  assign full = count_q == W'(MAX);
  always_comb begin
    count_d = (take && !give) ? count_q - 1'b1
            : (give && !take && !full) ? count_q + 1'b1 : count_q;
    err_d = err_q | (give & ~take & full);
  end
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      count_q <= W'(MAX);
      err_q <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q <= err_d;
    end
  end
  assign count = count_q;
  assign nonzero = count_q != '0;
  assign overflow = err_q;
endmodule

// File: rtl/command_credit_arbiter.sv
// command_credit_arbiter: credit-gated read/write command arbiter feeding the PSL command register.
// Ports: clock, rstn (async active-low), bus (command_credit_arbiter_if.slave).
// ROUND_ROBIN_ARB_EN defined: alternating round-robin pointer; undefined: read has fixed priority.
module command_credit_arbiter import GLOBALS_AFU_PKG::*; #(
  parameter int CMD_WIDTH = 128,
  parameter int READ_CREDITS = CREDITS_READ,
  parameter int WRITE_CREDITS = CREDITS_WRITE
) (
  input logic clock,
  input logic rstn,
  command_credit_arbiter_if.slave bus
);
  logic read_nz, write_nz, read_elig, write_elig, read_grant, write_grant, pick_write;
  logic valid_q, is_write_q, is_write_d;
  logic [CMD_WIDTH-1:0] cmd_q, cmd_d;
  assign read_elig = bus.enabled_in & bus.read_cmd_valid & read_nz;
  assign write_elig = bus.enabled_in & bus.write_cmd_valid & write_nz;
`ifdef ROUND_ROBIN_ARB_EN
  cmd_dir_t ptr_q, ptr_d;
  assign pick_write = write_elig & (~read_elig | (ptr_q == CMD_WRITE));
  // The pointer only moves on a grant, and always to the side not just served.
  always_comb ptr_d = (read_grant | write_grant) ? (pick_write ? CMD_READ : CMD_WRITE) : ptr_q;
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) ptr_q <= CMD_READ;
    else ptr_q <= ptr_d;
  end
`else
  assign pick_write = write_elig & ~read_elig;
`endif
  assign write_grant = pick_write;
  assign read_grant = read_elig & ~pick_write;
  assign bus.read_cmd_grant = read_grant;
  assign bus.write_cmd_grant = write_grant;
  always_comb begin
    cmd_d = write_grant ? bus.write_cmd_in : read_grant ? bus.read_cmd_in : cmd_q;
    is_write_d = (read_grant | write_grant) ? write_grant : is_write_q;
  end
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      cmd_q <= '0;
      is_write_q <= 1'b0;
    end else begin
      valid_q <= read_grant | write_grant;
      cmd_q <= cmd_d;
      is_write_q <= is_write_d;
    end
  end
  assign bus.cmd_out_valid = valid_q;
  assign bus.cmd_out = cmd_q;
  assign bus.cmd_out_is_write = is_write_q;
  credit_counter #(.MAX(READ_CREDITS)) u_read_pool (
    .clock(clock), .rstn(rstn), .take(read_grant), .give(bus.read_rsp_done),
    .count(bus.read_credits_avail), .nonzero(read_nz), .overflow(bus.credit_overflow_error[0])
  );
  credit_counter #(.MAX(WRITE_CREDITS)) u_write_pool (
    .clock(clock), .rstn(rstn), .take(write_grant), .give(bus.write_rsp_done),
    .count(bus.write_credits_avail), .nonzero(write_nz), .overflow(bus.credit_overflow_error[1])
  );
endmodule

// File: tb/tb_command_credit_arbiter.sv
// tb_command_credit_arbiter: directed self-checking bench for command_credit_arbiter.
module tb_command_credit_arbiter;
  logic clock = 1'b0;
  logic rstn = 1'b0;
  int checks = 0;
  int passes = 0;
  int fails = 0;
  int grants;
  logic exp_w;
  command_credit_arbiter_if bus ();
  command_credit_arbiter dut (.clock(clock), .rstn(rstn), .bus(bus));
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  initial begin
    bus.enabled_in = 0;
    bus.read_cmd_valid = 0;
    bus.read_cmd_in = '0;
    bus.write_cmd_valid = 0;
    bus.write_cmd_in = '0;
    bus.read_rsp_done = 0;
    bus.write_rsp_done = 0;
    tick();
    tick();
    rstn = 1;
    chk("rst_rd_avail", bus.read_credits_avail, 32);
    chk("rst_wr_avail", bus.write_credits_avail, 32);
    chk("rst_valid", bus.cmd_out_valid, 0);
    chk("rst_cmd", bus.cmd_out, 0);
    chk("rst_is_write", bus.cmd_out_is_write, 0);
    chk("rst_err", bus.credit_overflow_error, 0);
    bus.enabled_in = 1;
    bus.read_cmd_valid = 1;
    grants = 0;
    for (int i = 0; i < 40; i++) begin
      bus.read_cmd_in = 128'(i);
      #1;
      if (bus.read_cmd_grant) grants++;
      tick();
    end
    chk("drain_grants", grants, 32);
    chk("drain_grant_low", bus.read_cmd_grant, 0);
    chk("drain_avail", bus.read_credits_avail, 0);
    chk("drain_valid", bus.cmd_out_valid, 0);
    chk("drain_cmd_held", bus.cmd_out, 31);
    bus.read_rsp_done = 1;
    #1;
    chk("ret_no_grant_yet", bus.read_cmd_grant, 0);
    tick();
    bus.read_rsp_done = 0;
    chk("ret_avail_1", bus.read_credits_avail, 1);
    #1;
    chk("ret_grant", bus.read_cmd_grant, 1);
    tick();
    chk("ret_avail_0", bus.read_credits_avail, 0);
    chk("ret_valid", bus.cmd_out_valid, 1);
    chk("ret_cmd", bus.cmd_out, 39);
    chk("ret_is_write", bus.cmd_out_is_write, 0);
    chk("ret_grant_off", bus.read_cmd_grant, 0);
    bus.read_cmd_valid = 0;
    bus.read_rsp_done = 1;
    for (int i = 0; i < 5; i++) tick();
    bus.read_rsp_done = 0;
    chk("refill_5", bus.read_credits_avail, 5);
    bus.read_cmd_valid = 1;
    bus.read_rsp_done = 1;
    #1;
    chk("same_cyc_grant", bus.read_cmd_grant, 1);
    tick();
    chk("same_cyc_avail", bus.read_credits_avail, 5);
    chk("same_cyc_valid", bus.cmd_out_valid, 1);
    bus.read_rsp_done = 0;
    bus.enabled_in = 0;
    bus.write_cmd_valid = 1;
    #1;
    chk("dis_rd_grant", bus.read_cmd_grant, 0);
    chk("dis_wr_grant", bus.write_cmd_grant, 0);
    bus.read_rsp_done = 1;
    tick();
    bus.read_rsp_done = 0;
    chk("dis_ret_avail", bus.read_credits_avail, 6);
    chk("dis_valid", bus.cmd_out_valid, 0);
    bus.write_rsp_done = 1;
    tick();
    bus.write_rsp_done = 0;
    chk("ovf_err", bus.credit_overflow_error, 2'b10);
    chk("ovf_wr_avail", bus.write_credits_avail, 32);
    tick();
    tick();
    chk("ovf_sticky", bus.credit_overflow_error, 2'b10);
    chk("ovf_rd_avail", bus.read_credits_avail, 6);
    rstn = 0;
    #1;
    chk("ovf_cleared", bus.credit_overflow_error, 0);
    tick();
    rstn = 1;
    bus.enabled_in = 1;
    bus.read_cmd_valid = 1;
    bus.write_cmd_valid = 1;
    bus.read_cmd_in = 128'hAAAA;
    bus.write_cmd_in = 128'hBBBB;
    for (int k = 0; k < 64; k++) begin
      tick();
`ifdef ROUND_ROBIN_ARB_EN
      exp_w = (k % 2) == 1;
`else
      exp_w = k >= 32;
`endif
      chk($sformatf("arb_dir_%0d", k), bus.cmd_out_is_write, exp_w);
      chk($sformatf("arb_cmd_%0d", k), bus.cmd_out, exp_w ? 128'hBBBB : 128'hAAAA);
    end
    bus.write_cmd_valid = 0;
    rstn = 0;
    tick();
    rstn = 1;
    for (int i = 0; i < 10; i++) tick();
    chk("pre_rst_avail", bus.read_credits_avail, 22);
    chk("pre_rst_valid", bus.cmd_out_valid, 1);
    #2;
    rstn = 0;
    #1;
    chk("async_rd_avail", bus.read_credits_avail, 32);
    chk("async_wr_avail", bus.write_credits_avail, 32);
    chk("async_valid", bus.cmd_out_valid, 0);
    chk("async_cmd", bus.cmd_out, 0);
    tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
